// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiply sequencer.
// Holds the FSM state encoding, the default operand width, the fixed latency
// constants and the operand-magnitude helper.
package mult_pkg;

  localparam int WIDTH          = 32;
  localparam int CNT_W          = 6;
  localparam int LAT_UNSIGNED   = 33;
  localparam int LAT_SIGNED_NEG = 35;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    NEG_LO = 3'd2,
    NEG_HI = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Absolute value for MULT operands. 0x80000000 maps onto itself, which is
  // the correct magnitude when the result is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/result bundle between the execute stage (master) and the multiply
// sequencer (slave).
interface mult_sequencer_if;
  import mult_pkg::*;

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, signed_op, a, b,
                  input  busy, done, hi, lo);

  modport slave  (input  start, signed_op, a, b,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mult_sequencer_adder.sv
// The single WIDTH-bit adder shared by every addition the sequencer makes.
module mult_sequencer_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = op_a + op_b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/mult_sequencer.sv
// MIPS MULT/MULTU shift-add sequencer: one partial-product addition per cycle
// on a single shared adder, followed by an optional two-step negation of the
// 64-bit HI:LO result for signed operands of differing sign.
// Build option: define MULT_EARLY_TERM_EN to finish RUN as soon as the
// remaining multiplier bits are all zero.
module mult_sequencer import mult_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic             z_q, z_d;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] partial;
  logic             carry;
`ifdef MULT_EARLY_TERM_EN
  logic             rem_zero;
`endif

  mult_sequencer_adder #(.WIDTH(WIDTH)) u_adder (
    .op_a (add_a),
    .op_b (add_b),
    .cin  (add_cin),
    .sum  (add_sum)
  );

  // Adder operand mux and the partial-product step seen in RUN.
  always_comb begin
    add_a   = hi_q;
    add_b   = mcand_q;
    add_cin = 1'b0;
    case (state_q)
      NEG_LO: begin
        add_a   = ~lo_q;
        add_b   = '0;
        add_cin = 1'b1;
      end
      NEG_HI: begin
        add_a   = ~hi_q;
        add_b   = '0;
        add_cin = z_q;
      end
      default: ;
    endcase
    partial = lo_q[0] ? add_sum : hi_q;
    carry   = lo_q[0] & (add_sum < hi_q);
`ifdef MULT_EARLY_TERM_EN
    // Multiplier bits not yet consumed sit in lo[cnt-1:0].
    rem_zero = ((lo_q & ~({WIDTH{1'b1}} << cnt_q)) == '0);
`endif
  end

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = magnitude(bus.a, bus.signed_op);
          lo_d    = magnitude(bus.b, bus.signed_op);
          hi_d    = '0;
          cnt_d   = CNT_W'(WIDTH);
          neg_d   = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MULT_EARLY_TERM_EN
        if (rem_zero) begin
          // No further additions can occur: apply all remaining shifts at once.
          {hi_d, lo_d} = {hi_q, lo_q} >> cnt_q;
          cnt_d        = '0;
          state_d      = neg_q ? NEG_LO : DONE;
        end else
`endif
        begin
          hi_d  = {carry, partial[WIDTH-1:1]};
          lo_d  = {partial[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = neg_q ? NEG_LO : DONE;
          end
        end
      end
      NEG_LO: begin
        lo_d    = add_sum;
        z_d     = (lo_q == '0);
        state_d = NEG_HI;
      end
      NEG_HI: begin
        hi_d    = add_sum;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy = (state_q == RUN) || (state_q == NEG_LO) || (state_q == NEG_HI);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes hand-computed HI:LO
// and latency expectations, a negedge monitor pops and checks them on done.
module tb_mult_sequencer;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_sequencer_if bus_if ();

  mult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected cycles from the start-sampling edge to done.
  function automatic int exp_lat(input bit sop, input logic [31:0] a, input logic [31:0] b);
    int l;
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] mb;
    mb = (sop && b[31]) ? (~b + 32'd1) : b;
    l  = 2;
    for (int i = 0; i < 32; i++) if (mb[i]) l = i + 3;
    if (l > LAT_UNSIGNED) l = LAT_UNSIGNED;
`else
    l = LAT_UNSIGNED;
`endif
    return (sop && (a[31] ^ b[31])) ? l + (LAT_SIGNED_NEG - LAT_UNSIGNED) : l;
  endfunction

  // Monitor: compare every done against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        if (sb.size() == 0) begin
          check("done_without_request", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"},   64'(bus_if.hi), 64'(e.hi));
          check({e.name, "_lo"},   64'(bus_if.lo), 64'(e.lo));
          check({e.name, "_lat"},  64'(cyc - e.t0), 64'(e.lat));
          check({e.name, "_busy"}, 64'(busy_cnt), 64'(e.lat - 1));
          check({e.name, "_busy_at_done"}, 64'(bus_if.busy), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input bit sop, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    exp_t e;
    @(posedge clk); #1;
    bus_if.start     = 1'b1;
    bus_if.signed_op = sop;
    bus_if.a         = a;
    bus_if.b         = b;
    e.hi = eh; e.lo = el; e.lat = exp_lat(sop, a, b); e.t0 = cyc; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus_if.busy || bus_if.done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    bus_if.start = 1'b0; bus_if.signed_op = 1'b0; bus_if.a = '0; bus_if.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    check("reset_hi",   64'(bus_if.hi),   64'd0);
    check("reset_lo",   64'(bus_if.lo),   64'd0);
    rst_n = 1'b1;

    issue(1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, "multu_3x5");
    wait_idle();
    repeat (3) @(posedge clk); #1;
    check("hold_hi", 64'(bus_if.hi), 64'h0);
    check("hold_lo", 64'(bus_if.lo), 64'hF);

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    wait_idle();
    issue(1'b1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m7x3");
    wait_idle();
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1xm1");
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin");
    wait_idle();
    issue(1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, "mult_0xm5");
    wait_idle();

    // 19239859 * 5435932 = 104586565213588 = 0x00005F1E_F5115D94
    issue(1'b0, 32'd19239859, 32'd5435932, 32'h0000_5F1E, 32'hF511_5D94, "multu_busy_start");
    repeat (8) @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.a = 32'd1; bus_if.b = 32'd1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    n = 0;
    while (!bus_if.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL wait_done: no done after %0d cycles, expected done", n);
    end
    // Start during the DONE cycle is dropped; held into IDLE it is taken.
    bus_if.start = 1'b1; bus_if.signed_op = 1'b0; bus_if.a = 32'd2; bus_if.b = 32'd2;
    @(posedge clk); #1;
    bus_if.a = 32'd7; bus_if.b = 32'd6;
    e.hi = 32'h0; e.lo = 32'h2A; e.lat = exp_lat(1'b0, 32'd7, 32'd6); e.t0 = cyc;
    e.name = "multu_after_done";
    sb.push_back(e);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a run.
    issue(1'b0, 32'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFD, "multu_aborted");
    repeat (13) @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_done", 64'(bus_if.done), 64'd0);
    check("abort_hi",   64'(bus_if.hi),   64'd0);
    check("abort_lo",   64'(bus_if.lo),   64'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk); #1;
    issue(1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_after_reset");
    wait_idle();

    repeat (2) @(posedge clk); #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
